// File: rtl/logic_op_if.sv
// logic_op_if
// Groups the sample-side and result-side signals of logic_op_pipe.
//   en, clr      : pipeline advance / synchronous flush (driven by master)
//   in_valid     : a_in/b_in/mode carry a sample this cycle (driven by master)
//   a_in, b_in   : WIDTH-bit operands (driven by master)
//   mode         : 3-bit operation tag captured with the sample (driven by master)
//   q_out        : registered result (driven by slave)
//   out_valid    : q_out carries a new result this cycle (driven by slave)
//   out_count    : saturating CNT_W-bit count of results (driven by slave)
// master = upstream producer / consumer side, slave = the pipeline itself.
interface logic_op_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) ();
    logic             en;
    logic             clr;
    logic             in_valid;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic [2:0]       mode;
    logic [WIDTH-1:0] q_out;
    logic             out_valid;
    logic [CNT_W-1:0] out_count;

    modport master (
        output en, clr, in_valid, a_in, b_in, mode,
        input  q_out, out_valid, out_count
    );

    modport slave (
        input  en, clr, in_valid, a_in, b_in, mode,
        output q_out, out_valid, out_count
    );
endinterface

// File: rtl/logic_op_pipe.sv
// logic_op_pipe
// Registered, stallable two-operand bitwise logic unit. Each sample travels
// through DEPTH input register stages together with its valid bit and mode
// tag, then a single output stage applies the tagged operation.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset, clears every register
//   bus      : logic_op_if slave modport (en, clr, in_valid, a_in, b_in,
//              mode in; q_out, out_valid, out_count out)
// Mode encoding: 000 NAND, 001 AND, 010 OR, 011 NOR, 100 XOR, 101 XNOR,
//                110 pass A, 111 NOT A.
// Latency is DEPTH+1 enabled edges from capture to q_out; clr beats en.
module logic_op_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    logic_op_if.slave   bus
);

    // Bitwise combine selected by the sample's own mode tag.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (m)
            3'b000:  r = ~(a & b);
            3'b001:  r = a & b;
            3'b010:  r = a | b;
            3'b011:  r = ~(a | b);
            3'b100:  r = a ^ b;
            3'b101:  r = ~(a ^ b);
            3'b110:  r = a;
            default: r = ~a;
        endcase
        return r;
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic [DEPTH-1:0] vld_p;
    logic [WIDTH-1:0] a_p    [DEPTH];
    logic [WIDTH-1:0] b_p    [DEPTH];
    logic [2:0]       mode_p [DEPTH];

    logic [WIDTH-1:0] q_r;
    logic             vld_out_r;
    logic [CNT_W-1:0] cnt_r;

    // Input register stages: index 0 loads from the bus, index k from k-1.
    // Operand data is loaded regardless of in_valid; only the valid bit
    // decides whether it is ever used downstream.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                a_p[k]    <= '0;
                b_p[k]    <= '0;
                mode_p[k] <= '0;
            end
        end else if (bus.clr) begin
            vld_p <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                a_p[k]    <= '0;
                b_p[k]    <= '0;
                mode_p[k] <= '0;
            end
        end else if (bus.en) begin
            vld_p[0]  <= bus.in_valid;
            a_p[0]    <= bus.a_in;
            b_p[0]    <= bus.b_in;
            mode_p[0] <= bus.mode;
            for (int k = 1; k < DEPTH; k++) begin
                vld_p[k]  <= vld_p[k-1];
                a_p[k]    <= a_p[k-1];
                b_p[k]    <= b_p[k-1];
                mode_p[k] <= mode_p[k-1];
            end
        end
    end

    // Output stage: q_out only moves on a valid sample so it holds the last
    // result across bubbles; the counter tracks every out_valid=1 load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r       <= '0;
            vld_out_r <= 1'b0;
            cnt_r     <= '0;
        end else if (bus.clr) begin
            q_r       <= '0;
            vld_out_r <= 1'b0;
            cnt_r     <= '0;
        end else if (bus.en) begin
            vld_out_r <= vld_p[DEPTH-1];
            if (vld_p[DEPTH-1]) begin
                q_r   <= logic_op(mode_p[DEPTH-1], a_p[DEPTH-1], b_p[DEPTH-1]);
                cnt_r <= sat_inc(cnt_r);
            end
        end
    end

    assign bus.q_out     = q_r;
    assign bus.out_valid = vld_out_r;
    assign bus.out_count = cnt_r;

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe
// Drives a default logic_op_pipe (WIDTH=8, DEPTH=2, CNT_W=16) and a CNT_W=3
// copy with identical stimulus. A timestamp-queue reference model predicts
// q_out/out_valid/out_count every cycle; table vectors and short hand-written
// sequences cover reset, mode sweep, stall, bubbles, clear and saturation.
module tb_logic_op_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 2;

    logic clk;
    logic reset_n;

    logic_op_if #(.WIDTH(WIDTH), .CNT_W(16)) bus  ();
    logic_op_if #(.WIDTH(WIDTH), .CNT_W(3))  sbus ();

    assign sbus.en       = bus.en;
    assign sbus.clr      = bus.clr;
    assign sbus.in_valid = bus.in_valid;
    assign sbus.a_in     = bus.a_in;
    assign sbus.b_in     = bus.b_in;
    assign sbus.mode     = bus.mode;

    logic_op_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    logic_op_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(3)) dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Reference model: a sample captured on the e-th enabled edge shows up
    // on the output after enabled edge e+DEPTH.
    typedef struct {
        int         e;
        logic [7:0] r;
    } pend_t;

    pend_t      pq[$];
    int         ecnt;
    logic [7:0] m_q;
    logic       m_v;
    int         m_cnt;

    function automatic logic [7:0] ref_op(input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
        case (m)
            3'd0: return 8'hFF ^ (a & b);
            3'd1: return a & b;
            3'd2: return a | b;
            3'd3: return 8'hFF ^ (a | b);
            3'd4: return a ^ b;
            3'd5: return 8'hFF ^ (a ^ b);
            3'd6: return a;
            default: return 8'hFF ^ a;
        endcase
    endfunction

    task automatic model_reset();
        pq.delete();
        ecnt  = 0;
        m_q   = '0;
        m_v   = 1'b0;
        m_cnt = 0;
    endtask

    task automatic model_edge();
        pend_t p;
        if (bus.clr) begin
            pq.delete();
            m_q   = '0;
            m_v   = 1'b0;
            m_cnt = 0;
        end else if (bus.en) begin
            ecnt++;
            m_v = 1'b0;
            if (pq.size() > 0 && pq[0].e + DEPTH == ecnt) begin
                p = pq.pop_front();
                m_v = 1'b1;
                m_q = p.r;
                m_cnt++;
            end
            if (bus.in_valid) begin
                p.e = ecnt;
                p.r = ref_op(bus.mode, bus.a_in, bus.b_in);
                pq.push_back(p);
            end
        end
    endtask

    task automatic check_model();
        chk("q_out", bus.q_out, m_q);
        chk("out_valid", bus.out_valid, m_v);
        chk("out_count", bus.out_count, (m_cnt > 65535) ? 65535 : m_cnt);
        chk("sat_q_out", sbus.q_out, m_q);
        chk("sat_out_count", sbus.out_count, (m_cnt > 7) ? 7 : m_cnt);
    endtask

    // Advance one clock; model sees the inputs as the DUT sees them at the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic drive(input logic v, input logic [2:0] m, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid = v;
        bus.mode     = m;
        bus.a_in     = a;
        bus.b_in     = b;
    endtask

    task automatic do_clear();
        bus.clr = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        bus.clr = 1'b0;
    endtask

    typedef struct {
        logic [2:0] mode;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[8];

    initial begin
        tbl[0] = '{3'd0, 8'hF0, 8'hCC, 8'h3F};
        tbl[1] = '{3'd1, 8'hF0, 8'hCC, 8'hC0};
        tbl[2] = '{3'd2, 8'hF0, 8'hCC, 8'hFC};
        tbl[3] = '{3'd3, 8'hF0, 8'hCC, 8'h03};
        tbl[4] = '{3'd4, 8'hF0, 8'hCC, 8'h3C};
        tbl[5] = '{3'd5, 8'hF0, 8'hCC, 8'hC3};
        tbl[6] = '{3'd6, 8'hF0, 8'hCC, 8'hF0};
        tbl[7] = '{3'd7, 8'hF0, 8'hCC, 8'h0F};

        reset_n = 1'b0;
        bus.en  = 1'b1;
        bus.clr = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        model_reset();
        #2;
        chk("reset_q_out", bus.q_out, 8'h00);
        chk("reset_out_valid", bus.out_valid, 1'b0);
        chk("reset_out_count", bus.out_count, 16'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Single sample latency.
        drive(1'b1, 3'd0, 8'hF0, 8'hCC);
        for (int j = 0; j < 4; j++) begin
            tick();
            drive(1'b0, 3'd0, 8'h00, 8'h00);
            chk("lat_valid", bus.out_valid, (j == 2) ? 1'b1 : 1'b0);
            if (j == 2) chk("lat_q", bus.q_out, 8'h3F);
        end
        chk("lat_count", bus.out_count, 16'd1);

        // Mode sweep, one sample per cycle.
        do_clear();
        for (int j = 0; j < 11; j++) begin
            if (j < 8) drive(1'b1, tbl[j].mode, tbl[j].a, tbl[j].b);
            else       drive(1'b0, 3'd0, 8'h00, 8'h00);
            tick();
            if (j >= 2 && j < 10) begin
                chk("sweep_q", bus.q_out, tbl[j-2].exp);
                chk("sweep_valid", bus.out_valid, 1'b1);
            end
        end
        chk("sweep_count", bus.out_count, 16'd8);

        // Stall for 3 cycles mid-stream.
        do_clear();
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 3'(j + 2), 8'(8'h11 * (j + 1)), 8'h5A);
            tick();
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        bus.en = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(1'b1, 3'd0, 8'hFF, 8'hFF);
            tick();
            chk("stall_count", bus.out_count, 16'd2);
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        bus.en = 1'b1;
        for (int j = 0; j < 4; j++) tick();
        chk("stall_total", bus.out_count, 16'd4);

        // Bubble pattern 1,0,1.
        do_clear();
        drive(1'b1, 3'd0, 8'hF0, 8'hCC); tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00); tick();
        drive(1'b1, 3'd1, 8'hF0, 8'hCC); tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("bub_v0", bus.out_valid, 1'b1);
        chk("bub_q0", bus.q_out, 8'h3F);
        tick();
        chk("bub_v1", bus.out_valid, 1'b0);
        chk("bub_q1", bus.q_out, 8'h3F);
        tick();
        chk("bub_v2", bus.out_valid, 1'b1);
        chk("bub_q2", bus.q_out, 8'hC0);
        tick();

        // Clear with two samples in flight, en low.
        drive(1'b1, 3'd2, 8'h0F, 8'h30); tick();
        drive(1'b1, 3'd4, 8'h55, 8'hAA); tick();
        bus.en  = 1'b0;
        bus.clr = 1'b1;
        drive(1'b1, 3'd6, 8'h77, 8'h00);
        tick();
        bus.clr = 1'b0;
        bus.en  = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        chk("clr_q", bus.q_out, 8'h00);
        chk("clr_valid", bus.out_valid, 1'b0);
        chk("clr_count", bus.out_count, 16'd0);
        for (int j = 0; j < 4; j++) begin
            tick();
            chk("clr_flushed", bus.out_valid, 1'b0);
        end

        // Saturation on the CNT_W=3 copy, then asynchronous reset.
        for (int j = 0; j < 10; j++) begin
            drive(1'b1, 3'd6, 8'hA5, 8'h00);
            tick();
        end
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        for (int j = 0; j < 3; j++) tick();
        chk("sat_stop", sbus.out_count, 3'd7);
        chk("sat_wide", bus.out_count, 16'd10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_q", bus.q_out, 8'h00);
        chk("arst_count", bus.out_count, 16'd0);
        chk("arst_sat_q", sbus.q_out, 8'h00);
        chk("arst_sat_count", sbus.out_count, 3'd0);
        model_reset();
        @(posedge clk);
        #1;
        check_model();
        reset_n = 1'b1;

        // Randomized traffic against the model.
        for (int j = 0; j < 400; j++) begin
            bus.en  = ($urandom_range(0, 9) < 8);
            bus.clr = ($urandom_range(0, 49) == 0);
            drive(($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            tick();
        end
        bus.clr = 1'b0;
        bus.en  = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        for (int j = 0; j < 4; j++) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/logic_op_pipe.md
# logic_op_pipe

Parametrised registered two-operand logic unit, the multi-bit, multi-mode successor to the single-bit registered-NAND flop cell. Operands pass through DEPTH input register stages with per-sample valid and mode tags, then one output stage applies the selected bitwise operation. It sits between the operand-capture registers and downstream datapath logic wherever a timing-isolated, stallable bitwise combine is needed.

## Interface
- WIDTH, 8, operand/result width in bits (≥1)
- DEPTH, 2, input register stages before the output stage (≥1)
- CNT_W, 16, width of the output-sample counter (≥1)

- clk  input  1  clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- en  input  1  pipeline advance; 0 = every stage holds
- clr  input  1  synchronous clear, priority over en
- in_valid  input  1  a_in/b_in/mode form a sample this cycle
- a_in  input  WIDTH  operand A
- b_in  input  WIDTH  operand B
- mode  input  3  operation, captured with the sample
- q_out  output  WIDTH  registered result
- out_valid  output  1  q_out holds a new result this cycle
- out_count  output  CNT_W  saturating count of results produced

## Operation
- Stage k (1..DEPTH) holds {valid, a, b, mode}; stage 1 loads from inputs, stage k from stage k-1.
- Mode encoding (bitwise over WIDTH): 000 NAND, 001 AND, 010 OR, 011 NOR, 100 XOR, 101 XNOR, 110 pass A, 111 NOT A. 000 is the legacy cell behaviour.
- Mode is tagged per sample: changing mode mid-stream affects only samples captured after the change.
- Output stage, when en=1 and clr=0: out_valid <= stage DEPTH valid; if stage DEPTH valid, q_out <= op(mode_D, a_D, b_D), else q_out holds its previous value.
- out_count increments by 1 on each cycle out_valid is loaded with 1; saturates at 2^CNT_W-1, no wrap.
- en=0, clr=0: all stage registers, q_out, out_valid, out_count hold. in_valid is ignored (sample dropped; upstream must hold off).
- clr=1 (any en): all stage valids/data/modes, q_out, out_valid, out_count go to 0 next edge; a sample presented with clr=1 is dropped.

## Timing
- Reset (reset_n=0, asynchronous, immediate): q_out=0, out_valid=0, out_count=0, all stage valids/data/modes=0. Note q_out=0 on reset even though NAND(0,0) would be all ones.
- Reset mid-stream discards all in-flight samples; the first sample after release is captured on the first rising edge with reset_n=1.
- Latency: sample presented on edge N appears on q_out/out_valid after edge N+DEPTH+1 when en=1 throughout; each en=0 cycle adds one cycle.
- Throughput: one sample per cycle with en=1; back-to-back samples emerge back-to-back.
- out_valid is a single-cycle-per-sample pulse; it stays 1 across consecutive valid samples and holds its value while en=0.
- No combinational path from any input to any output.

## Test plan
- Reset/latency: WIDTH=8, DEPTH=2, en=1; after reset q_out=0x00, out_valid=0; present a=0xF0, b=0xCC, mode=000 once -> q_out=0x3F, out_valid=1 exactly 3 cycles later for one cycle, out_count=1.
- Mode sweep: a=0xF0, b=0xCC, modes 000..111 on consecutive cycles -> q_out sequence 0x3F, 0xC0, 0xFC, 0x03, 0x3C, 0xC3, 0xF0, 0x0F on 8 consecutive cycles, out_count=8.
- Stall: stream 4 samples, drop en for 3 cycles mid-stream -> outputs identical in value and order, delayed exactly 3 cycles; q_out/out_valid/out_count frozen during stall.
- Bubbles: in_valid pattern 1,0,1 -> out_valid 1,0,1; q_out during the bubble equals the first result.
- Clear priority: with 2 samples in flight assert clr=1, en=0 for one cycle -> next cycle q_out=0, out_valid=0, out_count=0, no further outputs from the flushed samples.
- Saturation and async reset: CNT_W=3, stream 10 samples -> out_count stops at 7; then pulse reset_n low between edges -> outputs 0 immediately, before the next clk edge.
